// File: rtl/wormhole_output_arbiter_pkg.sv
// Shared router definitions: flit-type encoding, arbiter states and flit-type helpers.
// Flit type lives in data[DW-1:DW-2] of every flit.
package wormhole_output_arbiter_pkg;

  localparam int DW = 34;

  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/wormhole_output_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first request at or after ptr_i (wrapping) wins.
// Zero latency; no storage, the caller owns the pointer.
module wormhole_output_arbiter_rr_arbiter #(
  parameter int N  = 6,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          any_o
);

  int w_idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr_i) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!any_o && req_i[w_idx[PW-1:0]]) begin
        grant_o[w_idx[PW-1:0]] = 1'b1;
        any_o                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Wormhole output arbiter: round-robin grant on head flits, lock held until the tail fires.
// Grant 1 cycle after request; ready/valid to the locked input follow out_ready_i combinationally.
module wormhole_output_arbiter
  import wormhole_output_arbiter_pkg::*;
#(
  parameter int N_IN = 6,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req_valid_i,
  input  logic [2*N_IN-1:0] req_type_i,
  input  logic              out_avail_i,
  input  logic              out_ready_i,
  output logic [N_IN-1:0]   grant_o,
  output logic              locked_o,
  output logic [N_IN-1:0]   ready_o,
  output logic              out_valid_o,
  output logic              flit_fire_o,
  output logic              avail_reset_o,
  output logic [CW-1:0]     pkt_cnt_o,
  output logic              err_o
);

  localparam int PW = $clog2(N_IN);

  arb_state_t      r_state;
  logic [PW-1:0]   r_ptr;
  logic [N_IN-1:0] r_grant;
  logic            r_locked;
  logic            r_avail_reset;
  logic [CW-1:0]   r_pkt_cnt;
  logic            r_err;
  logic            r_first_done;  // the packet's opening head has already gone out

  logic [N_IN-1:0] w_elig;
  logic [N_IN-1:0] w_pick;
  logic            w_any;
  logic [PW-1:0]   w_gidx;
  logic [1:0]      w_gtype;
  logic            w_gvalid;
  logic            w_fire;
  logic [PW-1:0]   w_ptr_nxt;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_elig[i] = req_valid_i[i] & is_head(req_type_i[2*i +: 2]);
    end
  end

  wormhole_output_arbiter_rr_arbiter #(
    .N  (N_IN),
    .PW (PW)
  ) u_rr (
    .req_i   (w_elig),
    .ptr_i   (r_ptr),
    .grant_o (w_pick),
    .any_o   (w_any)
  );

  always_comb begin
    w_gidx   = '0;
    w_gtype  = FLIT_BODY;
    w_gvalid = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_grant[i]) begin
        w_gidx   = PW'(i);
        w_gtype  = req_type_i[2*i +: 2];
        w_gvalid = req_valid_i[i];
      end
    end
  end

  assign w_fire    = r_locked & w_gvalid & out_ready_i;
  assign w_ptr_nxt = (w_gidx == PW'(N_IN - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_locked      <= 1'b0;
      r_avail_reset <= 1'b0;
      r_pkt_cnt     <= '0;
      r_err         <= 1'b0;
      r_first_done  <= 1'b0;
    end else begin
      r_avail_reset <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (out_avail_i && w_any) begin
            r_state       <= ST_LOCKED;
            r_grant       <= w_pick;
            r_locked      <= 1'b1;
            r_avail_reset <= 1'b1;
            r_first_done  <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (w_fire) begin
            r_first_done <= 1'b1;
            if (is_tail(w_gtype)) begin
              r_state   <= ST_IDLE;
              r_grant   <= '0;
              r_locked  <= 1'b0;
              r_ptr     <= w_ptr_nxt;
              r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (w_gtype == FLIT_HEAD && r_first_done) begin
              // Stray head inside an open packet: flag it but keep forwarding.
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign locked_o      = r_locked;
  assign avail_reset_o = r_avail_reset;
  assign pkt_cnt_o     = r_pkt_cnt;
  assign err_o         = r_err;
  assign out_valid_o   = r_locked & w_gvalid;
  assign flit_fire_o   = w_fire;
  assign ready_o       = r_locked ? (r_grant & {N_IN{out_ready_i}}) : '0;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter; expected values are hand-derived per step.
module tb_wormhole_output_arbiter;

  localparam logic [1:0] HD = 2'b00;
  localparam logic [1:0] BD = 2'b01;
  localparam logic [1:0] TL = 2'b10;
  localparam logic [1:0] SG = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  req_valid;
  logic [11:0] req_type;
  logic        out_avail;
  logic        out_ready;
  logic [5:0]  grant;
  logic        locked;
  logic [5:0]  ready;
  logic        out_valid;
  logic        fire;
  logic        avail_reset;
  logic [15:0] pkt_cnt;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wormhole_output_arbiter #(.N_IN(6), .CW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_type_i    (req_type),
    .out_avail_i   (out_avail),
    .out_ready_i   (out_ready),
    .grant_o       (grant),
    .locked_o      (locked),
    .ready_o       (ready),
    .out_valid_o   (out_valid),
    .flit_fire_o   (fire),
    .avail_reset_o (avail_reset),
    .pkt_cnt_o     (pkt_cnt),
    .err_o         (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_type(input int i, input logic [1:0] t);
    req_type[2*i +: 2] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected grant order when inputs 0, 3, 5 keep offering SINGLE flits.
  logic [5:0] exp_order [4] = '{6'b000001, 6'b001000, 6'b100000, 6'b000001};
  logic       rdy_pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_type  = {6{BD}};
    out_avail = 1'b0;
    out_ready = 1'b0;
    do_reset();

    check_eq("rst_grant",  32'(grant), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_cnt",    32'(pkt_cnt), 32'd0);
    check_eq("rst_avrst",  32'(avail_reset), 32'd0);
    check_eq("rst_err",    32'(err), 32'd0);
    check_eq("rst_ready",  32'(ready), 32'd0);
    check_eq("rst_oval",   32'(out_valid), 32'd0);

    // Head/body/tail on input 2.
    out_avail = 1'b1;
    out_ready = 1'b1;
    req_valid = 6'b000100;
    set_type(2, HD);
    #1;
    check_eq("t1_idle_nofire", 32'(fire), 32'd0);
    tick();
    check_eq("t1_grant",  32'(grant), 32'b000100);
    check_eq("t1_avrst",  32'(avail_reset), 32'd1);
    check_eq("t1_locked", 32'(locked), 32'd1);
    check_eq("t1_fire_h", 32'(fire), 32'd1);
    check_eq("t1_ready",  32'(ready), 32'b000100);
    tick();
    check_eq("t1_avrst_once", 32'(avail_reset), 32'd0);
    check_eq("t1_err_first_head", 32'(err), 32'd0);
    set_type(2, BD);
    #1;
    check_eq("t1_fire_b", 32'(fire), 32'd1);
    tick();
    set_type(2, TL);
    #1;
    check_eq("t1_fire_t", 32'(fire), 32'd1);
    tick();
    req_valid = '0;
    check_eq("t1_rel_grant", 32'(grant), 32'd0);
    check_eq("t1_cnt",       32'(pkt_cnt), 32'd1);
    check_eq("t1_rel_locked", 32'(locked), 32'd0);

    // Heads on 2 and 3: ptr=3 must prefer 3.
    req_valid = 6'b001100;
    set_type(2, SG);
    set_type(3, SG);
    tick();
    check_eq("t1_ptr3_grant", 32'(grant), 32'b001000);
    req_valid = 6'b001000;
    tick();
    check_eq("t1_ptr3_cnt", 32'(pkt_cnt), 32'd2);
    req_valid = '0;

    // Reset returns ptr to 0; inputs 0,3,5 offer SINGLE flits continuously.
    do_reset();
    req_type  = {6{BD}};
    set_type(0, SG);
    set_type(3, SG);
    set_type(5, SG);
    req_valid = 6'b101001;
    for (int p = 0; p < 4; p++) begin
      tick();
      check_eq($sformatf("t2_grant%0d", p), 32'(grant), 32'(exp_order[p]));
      check_eq($sformatf("t2_fire%0d", p), 32'(fire), 32'd1);
      tick();
      check_eq($sformatf("t2_bubble%0d", p), 32'(grant), 32'd0);
      check_eq($sformatf("t2_cnt%0d", p), 32'(pkt_cnt), 32'(p + 1));
    end
    req_valid = '0;
    req_type  = {6{HD}};

    // Input 1 locked while out_ready toggles; ptr is now 1.
    req_valid = 6'b000010;
    tick();
    check_eq("t3_grant", 32'(grant), 32'b000010);
    tick();
    req_valid = 6'b111111;
    set_type(1, BD);
    for (int k = 0; k < 4; k++) begin
      out_ready = rdy_pat[k];
      #1;
      check_eq($sformatf("t3_fire%0d", k), 32'(fire), 32'(rdy_pat[k]));
      check_eq($sformatf("t3_ready%0d", k), 32'(ready), rdy_pat[k] ? 32'b000010 : 32'd0);
      tick();
      check_eq($sformatf("t3_lock%0d", k), 32'(locked), 32'd1);
      check_eq($sformatf("t3_hold%0d", k), 32'(grant), 32'b000010);
    end
    out_ready = 1'b1;
    set_type(1, TL);
    tick();
    req_valid = '0;
    req_type  = {6{BD}};
    check_eq("t3_cnt", 32'(pkt_cnt), 32'd5);

    // out_avail low holds off a head on input 4.
    out_avail = 1'b0;
    req_valid = 6'b010000;
    set_type(4, HD);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t4_nogrant%0d", k), 32'(grant), 32'd0);
    end
    out_avail = 1'b1;
    tick();
    check_eq("t4_grant", 32'(grant), 32'b010000);
    check_eq("t4_avrst", 32'(avail_reset), 32'd1);
    out_avail = 1'b0;
    tick();
    set_type(4, TL);
    tick();
    req_valid = '0;
    check_eq("t4_cnt", 32'(pkt_cnt), 32'd6);
    out_avail = 1'b1;

    // Second head inside a packet on input 0 (ptr=5, wraps to 0).
    req_type  = {6{BD}};
    req_valid = 6'b000001;
    set_type(0, HD);
    tick();
    check_eq("t5_grant", 32'(grant), 32'b000001);
    tick();
    check_eq("t5_no_err_first", 32'(err), 32'd0);
    tick();
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_locked", 32'(locked), 32'd1);
    set_type(0, BD);
    tick();
    check_eq("t5_err_clear", 32'(err), 32'd0);
    set_type(0, TL);
    tick();
    req_valid = '0;
    check_eq("t5_rel", 32'(locked), 32'd0);
    check_eq("t5_cnt", 32'(pkt_cnt), 32'd7);

    // Reset mid-packet on input 5 (ptr=1).
    req_valid = 6'b100000;
    set_type(5, HD);
    tick();
    check_eq("t6_grant_pre", 32'(grant), 32'b100000);
    tick();
    set_type(5, BD);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_grant", 32'(grant), 32'd0);
    check_eq("t6_rst_cnt",   32'(pkt_cnt), 32'd0);
    check_eq("t6_rst_lock",  32'(locked), 32'd0);
    check_eq("t6_rst_err",   32'(err), 32'd0);
    check_eq("t6_rst_fire",  32'(fire), 32'd0);
    check_eq("t6_rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    req_type  = {6{BD}};
    req_valid = 6'b000010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t6_body_nogrant%0d", k), 32'(grant), 32'd0);
    end
    req_valid = 6'b100010;
    set_type(5, HD);
    tick();
    check_eq("t6_grant5", 32'(grant), 32'b100000);
    check_eq("t6_cnt0",   32'(pkt_cnt), 32'd0);
    check_eq("t6_ready1", 32'(ready[1]), 32'd0);
    check_eq("t6_err_after", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
